bitserial_multi_adder: RTL and testbench

//  Sums M operands delivered bit-serially, LSB first: each input beat carries bit k of all M operands.

---
 rtl/bitserial_multi_adder_if.sv | 27 ++
 rtl/bitserial_multi_adder.sv | 186 ++++++++++++++++++
 tb/tb_bitserial_multi_adder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/bitserial_multi_adder_if.sv
// Handshake bundle for the bit-serial multi-operand adder: beat input side and result word output side.
interface bitserial_multi_adder_if #(
    parameter int unsigned M     = 32,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned CNT_W = 16
) ();
    logic             in_vld;
    logic             in_rdy;
    logic [M-1:0]     in_bits;
    logic [CNT_W-1:0] num_words_i;
    logic             signed_i;
    logic             out_vld;
    logic             out_rdy;
    logic [OUT_W-1:0] out_data;
    logic             out_first;
    logic             out_last;

    modport master (
        output in_vld, in_bits, num_words_i, signed_i, out_rdy,
        input  in_rdy, out_vld, out_data, out_first, out_last
    );

    modport slave (
        input  in_vld, in_bits, num_words_i, signed_i, out_rdy,
        output in_rdy, out_vld, out_data, out_first, out_last
    );
endinterface

// File: rtl/bitserial_multi_adder.sv
// Sums M bit-serial operands (LSB first) via popcount plus running carry; results leave as
// OUT_W-bit words through a small registered FIFO, data words first, then the carry words.
module bitserial_multi_adder #(
    parameter int unsigned M          = 32,
    parameter int unsigned OUT_W      = 8,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bitserial_multi_adder_if.slave  bus,
    output logic                    busy
);
    localparam int unsigned PW          = $clog2(M) + 1;
    localparam int unsigned CW          = $clog2(M) + 2;
    localparam int unsigned CARRY_WORDS = ($clog2(M) + 1 + OUT_W - 1) / OUT_W;
    localparam int unsigned CXW         = CARRY_WORDS * OUT_W;
    localparam int unsigned BW          = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int unsigned FW          = $clog2(FIFO_DEPTH);
    localparam int unsigned FCW         = $clog2(CARRY_WORDS + 1);

    typedef enum logic [1:0] {StIdle, StAcc, StFlush} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] nw_q, nw_d, word_q, word_d;
    logic             sgn_q, sgn_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [CW-1:0]    carry_q, carry_d;
    logic [OUT_W-1:0] asm_q, asm_d;
    logic [FCW-1:0]   fc_q, fc_d;

    logic [OUT_W-1:0] mem_data [FIFO_DEPTH];
    logic             mem_first [FIFO_DEPTH];
    logic             mem_last [FIFO_DEPTH];
    logic [FW-1:0]    wr_q, rd_q;
    logic [FW:0]      cnt_q;

    logic             fifo_full, fifo_empty, accept, pop;
    logic             push, push_first, push_last;
    logic [OUT_W-1:0] push_data;
    logic [PW-1:0]    popcnt;
    logic             idle, cur_sgn, last_bit, word_done;
    logic [CNT_W-1:0] cur_nw, cur_word;
    logic [BW-1:0]    cur_bit;
    logic [CW-1:0]    cur_carry;
    logic [OUT_W-1:0] cur_asm, asm_new;
    logic [CW:0]      carry_ext, pop_ext, t;
    logic             fill;
    logic [CXW+CW-1:0] carry_tmp;
    logic [CXW-1:0]   carry_wide;

    assign fifo_full  = (cnt_q == (FW+1)'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign bus.in_rdy = rst_n & (state_q != StFlush) & ~fifo_full;
    assign accept     = bus.in_vld & bus.in_rdy;
    assign pop        = bus.out_vld & bus.out_rdy;
    assign busy       = (state_q != StIdle);

    assign bus.out_vld   = ~fifo_empty;
    assign bus.out_data  = fifo_empty ? '0 : mem_data[rd_q];
    assign bus.out_first = ~fifo_empty & mem_first[rd_q];
    assign bus.out_last  = ~fifo_empty & mem_last[rd_q];

    always_comb begin
        popcnt = '0;
        for (int i = 0; i < int'(M); i++) begin
            popcnt = popcnt + PW'(bus.in_bits[i]);
        end
    end

    // In IDLE the beat being accepted is bit 0 of a fresh result, so use reset-like context.
    always_comb begin
        idle      = (state_q == StIdle);
        cur_nw    = idle ? ((bus.num_words_i == '0) ? CNT_W'(1) : bus.num_words_i) : nw_q;
        cur_sgn   = idle ? bus.signed_i : sgn_q;
        cur_bit   = idle ? '0 : bit_q;
        cur_word  = idle ? '0 : word_q;
        cur_carry = idle ? '0 : carry_q;
        cur_asm   = idle ? '0 : asm_q;
        word_done = (cur_bit == BW'(OUT_W - 1));
        last_bit  = word_done && (cur_word == cur_nw - 1'b1);
        carry_ext = {cur_carry[CW-1], cur_carry};
        pop_ext   = (CW+1)'(popcnt);
        t         = (cur_sgn && last_bit) ? (carry_ext - pop_ext) : (carry_ext + pop_ext);
        asm_new   = cur_asm;
        asm_new[cur_bit] = t[0];
        fill       = sgn_q & carry_q[CW-1];
        carry_tmp  = {{CXW{fill}}, carry_q};
        carry_wide = carry_tmp[CXW-1:0];
    end

    always_comb begin
        state_d    = state_q;
        nw_d       = nw_q;
        sgn_d      = sgn_q;
        bit_d      = bit_q;
        word_d     = word_q;
        carry_d    = carry_q;
        asm_d      = asm_q;
        fc_d       = fc_q;
        push       = 1'b0;
        push_first = 1'b0;
        push_last  = 1'b0;
        push_data  = '0;
        unique case (state_q)
            StIdle, StAcc: begin
                if (accept) begin
                    nw_d    = cur_nw;
                    sgn_d   = cur_sgn;
                    carry_d = t[CW:1];
                    if (word_done) begin
                        push       = 1'b1;
                        push_data  = asm_new;
                        push_first = (cur_word == '0);
                        bit_d      = '0;
                        word_d     = cur_word + 1'b1;
                        asm_d      = '0;
                    end else begin
                        bit_d  = cur_bit + 1'b1;
                        word_d = cur_word;
                        asm_d  = asm_new;
                    end
                    if (last_bit) begin
                        state_d = StFlush;
                        fc_d    = '0;
                    end else begin
                        state_d = StAcc;
                    end
                end
            end
            StFlush: begin
                if (!fifo_full) begin
                    push = 1'b1;
                    for (int w = 0; w < int'(CARRY_WORDS); w++) begin
                        if (fc_q == FCW'(w)) push_data = carry_wide[w*OUT_W +: OUT_W];
                    end
                    push_last = (fc_q == FCW'(CARRY_WORDS - 1));
                    fc_d      = fc_q + 1'b1;
                    if (push_last) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            nw_q    <= '0;
            sgn_q   <= 1'b0;
            bit_q   <= '0;
            word_q  <= '0;
            carry_q <= '0;
            asm_q   <= '0;
            fc_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            nw_q    <= nw_d;
            sgn_q   <= sgn_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            carry_q <= carry_d;
            asm_q   <= asm_d;
            fc_q    <= fc_d;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: the occupancy count gates every output.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_data[wr_q]  <= push_data;
            mem_first[wr_q] <= push_first;
            mem_last[wr_q]  <= push_last;
        end
    end
endmodule

// File: tb/tb_bitserial_multi_adder.sv
// Scoreboard bench for bitserial_multi_adder: directed operand sets with hand-computed result words.
module tb_bitserial_multi_adder;
    localparam int unsigned M          = 32;
    localparam int unsigned OUT_W      = 8;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int          LIMIT      = 200;

    typedef struct packed {
        logic       first;
        logic       last;
        logic [7:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [63:0] ops [M];

    always #5 clk = ~clk;

    bitserial_multi_adder_if #(.M(M), .OUT_W(OUT_W), .CNT_W(CNT_W)) ifc ();

    bitserial_multi_adder #(
        .M(M), .OUT_W(OUT_W), .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc.slave),
        .busy (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic first, input logic last, input logic [7:0] data);
        exp_t e;
        e.first = first;
        e.last  = last;
        e.data  = data;
        sb.push_back(e);
    endtask

    task automatic set_ops(input logic [63:0] v);
        for (int j = 0; j < int'(M); j++) ops[j] = v;
    endtask

    // Called at a negedge; returns at a negedge, leaving in_vld asserted.
    task automatic send_result(input int nw, input logic sgn, input int lim,
                               output int first_wait);
        int n;
        logic [M-1:0] b;
        n = ((nw == 0) ? 1 : nw) * int'(OUT_W);
        if (lim > 0 && lim < n) n = lim;
        first_wait = 0;
        for (int k = 0; k < n; k++) begin
            int w;
            for (int j = 0; j < int'(M); j++) b[j] = ops[j][k];
            ifc.in_bits     = b;
            ifc.in_vld      = 1'b1;
            ifc.num_words_i = CNT_W'(nw);
            ifc.signed_i    = sgn;
            #1;
            w = 0;
            while (!ifc.in_rdy && w < LIMIT) begin
                @(negedge clk);
                #1;
                w++;
            end
            if (w >= LIMIT) begin
                n_cmp++;
                n_bad++;
                $display("FAIL beat_timeout: beat %0d not accepted, got in_rdy=0, expected 1", k);
                return;
            end
            if (k == 0) first_wait = w;
            @(negedge clk);
        end
    endtask

    task automatic drain(input string name);
        int w = 0;
        while (sb.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        check({name, "_drained"}, sb.size(), 0);
        check({name, "_idle"}, busy, 1'b0);
    endtask

    // Monitor: pop expected word on every accepted output.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (ifc.out_vld && ifc.out_rdy) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got %0h, expected no word", ifc.out_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_word", {ifc.out_first, ifc.out_last, ifc.out_data}, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w0, w1;
        ifc.in_vld      = 1'b0;
        ifc.in_bits     = '0;
        ifc.num_words_i = '0;
        ifc.signed_i    = 1'b0;
        ifc.out_rdy     = 1'b1;
        set_ops(64'h0);

        repeat (3) @(negedge clk);
        #1;
        check("rst_in_rdy", ifc.in_rdy, 1'b0);
        check("rst_out_vld", ifc.out_vld, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_data", ifc.out_data, 8'h00);
        check("rst_first_last", {ifc.out_first, ifc.out_last}, 2'b00);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_rdy", ifc.in_rdy, 1'b1);
        @(negedge clk);

        // 32 x 0xFF unsigned = 0x1FE0
        set_ops(64'hFF);
        expect_word(1'b1, 1'b0, 8'hE0);
        expect_word(1'b0, 1'b1, 8'h1F);
        send_result(1, 1'b0, 0, w0);
        ifc.in_vld = 1'b0;
        drain("unsigned_ones");

        // 32 x (-1) signed = -32
        expect_word(1'b1, 1'b0, 8'hE0);
        expect_word(1'b0, 1'b1, 8'hFF);
        send_result(1, 1'b1, 0, w0);
        ifc.in_vld = 1'b0;
        drain("signed_ones");

        set_ops(64'h0);
        ops[0] = 64'h1234;
        expect_word(1'b1, 1'b0, 8'h34);
        expect_word(1'b0, 1'b0, 8'h12);
        expect_word(1'b0, 1'b1, 8'h00);
        send_result(2, 1'b0, 0, w0);
        ifc.in_vld = 1'b0;
        drain("two_words");

        // Backpressure: FIFO fills after 4 words, then releases all 9 in order
        ops[0] = 64'h0807060504030201;
        expect_word(1'b1, 1'b0, 8'h01);
        for (int i = 2; i <= 8; i++) expect_word(1'b0, 1'b0, 8'(i));
        expect_word(1'b0, 1'b1, 8'h00);
        ifc.out_rdy = 1'b0;
        fork
            send_result(8, 1'b0, 0, w0);
            begin
                repeat (60) @(negedge clk);
                #1;
                check("bp_in_rdy_low", ifc.in_rdy, 1'b0);
                check("bp_out_vld", ifc.out_vld, 1'b1);
                check("bp_busy", busy, 1'b1);
                check("bp_head_held", {ifc.out_first, ifc.out_data}, {1'b1, 8'h01});
                check("bp_none_popped", sb.size(), 9);
                @(negedge clk);
                ifc.out_rdy = 1'b1;
            end
        join
        ifc.in_vld = 1'b0;
        drain("backpressure");

        // Reset after 5 beats discards the partial result
        set_ops(64'hFF);
        send_result(1, 1'b0, 5, w0);
        ifc.in_vld = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_out_vld", ifc.out_vld, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_in_rdy", ifc.in_rdy, 1'b1);
        @(negedge clk);
        expect_word(1'b1, 1'b0, 8'hE0);
        expect_word(1'b0, 1'b1, 8'h1F);
        send_result(1, 1'b0, 0, w0);
        ifc.in_vld = 1'b0;
        drain("after_reset");

        // num_words=0 acts as 1; second result accepted one cycle after the FLUSH cycle
        set_ops(64'h0);
        ops[1] = 64'h01;
        for (int r = 0; r < 2; r++) begin
            expect_word(1'b1, 1'b0, 8'h01);
            expect_word(1'b0, 1'b1, 8'h00);
        end
        send_result(0, 1'b0, 0, w0);
        send_result(0, 1'b0, 0, w1);
        ifc.in_vld = 1'b0;
        check("b2b_first_wait", w0, 0);
        check("b2b_gap", w1, 1);
        drain("zero_words");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
